// File: rtl/data_memory_ctrl_if.sv
// Request/response bus for data_memory_ctrl.
// The master issues load/store requests; the slave (the memory) answers
// one cycle after acceptance. busy flags the self-initialisation phase.
interface data_memory_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           write_data;
  logic                  resp_valid;
  logic [31:0]           read_data;
  logic                  fault;
  logic                  busy;

  modport master (
    output req_valid, req_write, funct3, address, write_data,
    input  req_ready, resp_valid, read_data, fault, busy
  );

  modport slave (
    input  req_valid, req_write, funct3, address, write_data,
    output req_ready, resp_valid, read_data, fault, busy
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed RV32I data memory with a valid/ready request port, a
// registered response (latency 1) and a self-initialising reset sequence.
//
// Optional macro MISALIGN_FAULT_EN: when defined, misaligned H/HU/W
// requests are rejected with fault=1. When undefined they are silently
// aligned (H clears bit 0, W clears bits 1:0) and complete normally.
//
// state   | meaning
// ST_INIT | writing the init pattern, one word per cycle; not ready
// ST_IDLE | accepting one request per cycle
module data_memory_ctrl #(
  parameter int DEPTH        = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int INIT_PATTERN = 1
) (
  input  logic                clock,
  input  logic                reset,
  data_memory_ctrl_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH);

  // The word index plus byte offset must fit in the address.
  if (ADDR_WIDTH < IDX_W + 2) begin : g_bad_addr_width
    $error("data_memory_ctrl: ADDR_WIDTH too small for DEPTH");
  end

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             fault_q, fault_d;

  logic [31:0]      mem [DEPTH];

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       size;
  logic             is_unsigned;
  logic             illegal;
  logic             misaligned;
  logic             reject;
  logic [1:0]       lane_off;
  logic [3:0]       st_mask;
  logic [31:0]      st_data;
  logic [31:0]      ld_shifted;
  logic [31:0]      ld_ext;

  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_wmask;

  assign word_idx    = bus.address[IDX_W+1:2];
  assign size        = bus.funct3[1:0];
  assign is_unsigned = bus.funct3[2];

  // Decode width code, legality, alignment and the effective byte lane.
  always_comb begin
    illegal    = (size == 2'b11)
               | (is_unsigned & (size == 2'b10))
               | (bus.req_write & is_unsigned);
    misaligned = ((size == 2'b01) & bus.address[0])
               | ((size == 2'b10) & (bus.address[1:0] != 2'b00));
`ifdef MISALIGN_FAULT_EN
    reject     = illegal | misaligned;
`else
    reject     = illegal;
`endif
    lane_off = bus.address[1:0];
    if (size == 2'b01) lane_off[0] = 1'b0;
    if (size == 2'b10) lane_off    = 2'b00;
  end

  // Build the store byte mask/data and the extended load value.
  always_comb begin
    st_mask = 4'b1111;
    st_data = bus.write_data;
    case (size)
      2'b00: begin
        st_mask = 4'b0001 << lane_off;
        st_data = {4{bus.write_data[7:0]}};
      end
      2'b01: begin
        st_mask = 4'b0011 << lane_off;
        st_data = {2{bus.write_data[15:0]}};
      end
      default: ;
    endcase

    ld_shifted = mem[word_idx] >> {lane_off, 3'b000};
    case (size)
      2'b00:   ld_ext = is_unsigned ? {24'd0, ld_shifted[7:0]}
                                    : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      2'b01:   ld_ext = is_unsigned ? {16'd0, ld_shifted[15:0]}
                                    : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_ext = ld_shifted;
    endcase
  end

  // Next-state, memory write controls and response values.
  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    resp_valid_d = 1'b0;
    read_data_d  = read_data_q;
    fault_d      = fault_q;
    mem_we       = 1'b0;
    mem_widx     = word_idx;
    mem_wdata    = st_data;
    mem_wmask    = st_mask;

    case (state_q)
      ST_INIT: begin
        mem_we     = 1'b1;
        mem_widx   = init_idx_q;
        mem_wdata  = (INIT_PATTERN != 0) ? 32'(init_idx_q) : 32'd0;
        mem_wmask  = 4'b1111;
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == IDX_W'(DEPTH - 1)) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.req_valid) begin
          resp_valid_d = 1'b1;
          if (reject) begin
            read_data_d = 32'd0;
            fault_d     = 1'b1;
          end else if (bus.req_write) begin
            mem_we      = 1'b1;
            read_data_d = 32'd0;
            fault_d     = 1'b0;
          end else begin
            read_data_d = ld_ext;
            fault_d     = 1'b0;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Control and response registers; reset restarts initialisation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_INIT;
      init_idx_q   <= '0;
      resp_valid_q <= 1'b0;
      read_data_q  <= 32'd0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      resp_valid_q <= resp_valid_d;
      read_data_q  <= read_data_d;
      fault_q      <= fault_d;
    end
  end

  // Byte-masked memory write; storage itself is not reset, INIT fills it.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q == ST_INIT);
  assign bus.resp_valid = resp_valid_q;
  assign bus.read_data  = read_data_q;
  assign bus.fault      = fault_q;

endmodule
